// File: rtl/imem_loader.sv
// Streams program words into the 2Kx32 instruction RAM from address 0 while holding the CPU.
// Define IMEM_LOADER_CHECKSUM_EN to build the running word-sum register; otherwise checksum reads 0.
`timescale 1ns/1ps

module imem_loader #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2048
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [11:0]       word_count,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic [31:0]       pc,
    output logic              cpu_hold,
    output logic              done,
    output logic              mem_cen,
    output logic              mem_wen,
    output logic              mem_oen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_datain,
    output logic [31:0]       checksum
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [ADDR_W:0] DEPTH_C  = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0] ADDR_ONE = 1;

    logic [1:0]      state;
    logic [ADDR_W:0] wr_addr;
    logic [ADDR_W:0] target;

    logic            load_active;
    logic            fire;
    logic            last_word;
    logic [31:0]     wc_ext;
    logic [ADDR_W:0] start_target;
    logic            unused_pc_hi;

    assign load_active = (state == LOAD);
    assign fire        = in_valid & load_active;
    assign last_word   = fire & (wr_addr == (target - ADDR_ONE));

    // Oversized requests are clamped so the final write lands on the top word with no wrap.
    assign wc_ext       = 32'(word_count);
    assign start_target = (wc_ext > 32'(DEPTH)) ? DEPTH_C : wc_ext[ADDR_W:0];

    assign unused_pc_hi = &{1'b0, pc[31:ADDR_W]};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            wr_addr <= '0;
            target  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        target  <= start_target;
                        wr_addr <= '0;
                        state   <= (word_count == 12'd0) ? DONE : LOAD;
                    end
                end
                LOAD: begin
                    if (fire) begin
                        wr_addr <= wr_addr + ADDR_ONE;
                        if (last_word) begin
                            state <= DONE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] sum_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
        end else if ((state == IDLE) && start) begin
            sum_q <= '0;
        end else if (fire) begin
            sum_q <= sum_q + 32'(in_data);
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = 32'h0;
`endif

    assign in_ready = load_active;
    assign done     = (state == DONE);

    // The write strobe follows the handshake combinationally so the RAM captures in_data on the accepting edge.
    // NOTE: every output gets a default before the case so no path leaves one unassigned and infers a latch.
    always_comb begin
        cpu_hold   = 1'b0;
        mem_cen    = 1'b0;
        mem_wen    = 1'b1;
        mem_oen    = 1'b0;
        mem_addr   = pc[ADDR_W-1:0];
        mem_datain = '0;
        case (state)
            LOAD: begin
                cpu_hold = 1'b1;
                mem_oen  = 1'b1;
                mem_addr = wr_addr[ADDR_W-1:0];
                if (fire) begin
                    mem_wen    = 1'b0;
                    mem_datain = in_data;
                end
            end
            DONE: begin
                cpu_hold = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: models the RAM from the write strobes and checks loads, gaps, clamp and reset.
`timescale 1ns/1ps

module tb_imem_loader;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 2048;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              start;
    logic [11:0]       word_count;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic [31:0]       pc;
    logic              cpu_hold;
    logic              done;
    logic              mem_cen;
    logic              mem_wen;
    logic              mem_oen;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_datain;
    logic [31:0]       checksum;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0]       ram [DEPTH];
    int                wr_cnt = 0;
    int                done_cnt = 0;
    int                hold_viol = 0;
    logic [ADDR_W-1:0] last_wr_addr = '0;

    imem_loader #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .word_count(word_count),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .pc        (pc),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .mem_cen   (mem_cen),
        .mem_wen   (mem_wen),
        .mem_oen   (mem_oen),
        .mem_addr  (mem_addr),
        .mem_datain(mem_datain),
        .checksum  (checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!mem_cen && !mem_wen) begin
            ram[mem_addr] <= mem_datain;
            wr_cnt        <= wr_cnt + 1;
            last_wr_addr  <= mem_addr;
            if (!cpu_hold) hold_viol <= hold_viol + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues start with in_valid also high; nothing may be accepted in IDLE.
    task automatic start_load(input logic [11:0] wc);
        start      = 1'b1;
        word_count = wc;
        in_valid   = 1'b1;
        in_data    = 32'hBAD0_0000;
        #1;
        check("start_ready", 32'(in_ready), 32'd0);
        check("start_wen",   32'(mem_wen),  32'd1);
        check("start_hold",  32'(cpu_hold), 32'd0);
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic feed(input int n, input logic [31:0] first, input logic [31:0] stride,
                        input logic [31:0] vpat, input int plen, input int budget,
                        output logic [31:0] sum);
        int sent = 0;
        int k = 0;
        sum = 32'h0;
        while (sent < n && k < budget) begin
            in_valid = vpat[k % plen];
            in_data  = first + 32'(sent) * stride;
            #1;
            if (in_valid) begin
                check("load_ready", 32'(in_ready), 32'd1);
                check("load_hold",  32'(cpu_hold), 32'd1);
                check("load_addr",  32'(mem_addr), 32'(sent));
                check("load_wen",   32'(mem_wen),  32'd0);
                check("load_data",  mem_datain,    in_data);
            end else begin
                check("gap_wen",  32'(mem_wen), 32'd1);
                check("gap_data", mem_datain,   32'd0);
            end
            if (in_valid && in_ready) begin
                sum = sum + in_data;
                sent++;
            end
            tick();
            k++;
        end
        in_valid = 1'b0;
        check("feed_budget", 32'(sent), 32'(n));
    endtask

    // Called in the DONE cycle; offers one more word that must be refused.
    task automatic finish_done(input logic [31:0] exp_sum, input int exp_done);
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        #1;
        check("done_pulse", 32'(done),     32'd1);
        check("done_hold",  32'(cpu_hold), 32'd1);
        check("done_ready", 32'(in_ready), 32'd0);
        check("done_wen",   32'(mem_wen),  32'd1);
        check("done_addr",  32'(mem_addr), 32'(pc[10:0]));
        tick();
        in_valid = 1'b0;
        #1;
        check("idle_done",  32'(done),     32'd0);
        check("idle_hold",  32'(cpu_hold), 32'd0);
        check("done_count", 32'(done_cnt), 32'(exp_done));
        check("checksum",   checksum,      CSUM_ON ? exp_sum : 32'h0);
    endtask

    initial begin
        int          w0;
        logic [31:0] s;

        rst        = 1'b1;
        start      = 1'b0;
        word_count = '0;
        in_valid   = 1'b0;
        in_data    = '0;
        pc         = 32'h0000_0123;

        #12;
        check("rst_addr",  32'(mem_addr), 32'h123);
        check("rst_wen",   32'(mem_wen),  32'd1);
        check("rst_oen",   32'(mem_oen),  32'd0);
        check("rst_cen",   32'(mem_cen),  32'd0);
        check("rst_hold",  32'(cpu_hold), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_done",  32'(done),     32'd0);
        check("rst_csum",  checksum,      32'h0);
        tick();
        rst = 1'b0;
        tick();
        check("idle_addr", 32'(mem_addr), 32'h123);
        check("idle_data", mem_datain,    32'h0);

        // Four words, continuous valid.
        w0 = wr_cnt;
        start_load(12'd4);
        feed(4, 32'h11, 32'h11, '1, 1, 20, s);
        finish_done(s, 1);
        check("csum_aa", checksum, CSUM_ON ? 32'hAA : 32'h0);
        check("wr4_count", 32'(wr_cnt - w0), 32'd4);
        for (int i = 0; i < 4; i++) check("wr4_ram", ram[i], 32'h11 * 32'(i + 1));

        // Three words with valid pattern 1,0,0,1,0,1.
        pc = 32'h0000_0456;
        w0 = wr_cnt;
        start_load(12'd3);
        feed(3, 32'h3000_0001, 32'h1, 32'h29, 6, 30, s);
        finish_done(s, 2);
        check("wr3_count", 32'(wr_cnt - w0), 32'd3);
        check("wr3_ram0", ram[0], 32'h3000_0001);
        check("wr3_ram1", ram[1], 32'h3000_0002);
        check("wr3_ram2", ram[2], 32'h3000_0003);

        // Zero-length load goes straight to DONE.
        w0 = wr_cnt;
        start_load(12'd0);
        finish_done(32'h0, 3);
        check("wr0_count", 32'(wr_cnt - w0), 32'd0);

        // Oversized request clamps to 2048 words.
        w0 = wr_cnt;
        start_load(12'hFFF);
        feed(2048, 32'hA000_0000, 32'h1, '1, 1, 2100, s);
        finish_done(s, 4);
        check("clamp_count", 32'(wr_cnt - w0),   32'd2048);
        check("clamp_last",  32'(last_wr_addr),  32'h7FF);
        check("clamp_top",   ram[11'h7FF],       32'hA000_07FF);
        check("clamp_bot",   ram[0],             32'hA000_0000);

        // Reset two words into a five-word load.
        w0 = wr_cnt;
        start_load(12'd5);
        feed(2, 32'h7000_0000, 32'h1, '1, 1, 10, s);
        in_valid = 1'b1;
        in_data  = 32'h7000_0002;
        #3;
        rst = 1'b1;
        #1;
        check("mid_rst_hold",  32'(cpu_hold), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd0);
        check("mid_rst_done",  32'(done),     32'd0);
        check("mid_rst_wen",   32'(mem_wen),  32'd1);
        check("mid_rst_addr",  32'(mem_addr), 32'h456);
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        tick();
        tick();
        check("mid_rst_nodone", 32'(done_cnt),     32'd4);
        check("mid_rst_writes", 32'(wr_cnt - w0),  32'd2);
        check("mid_rst_csum",   checksum,          32'h0);

        start_load(12'd1);
        feed(1, 32'h0000_5555, 32'h0, '1, 1, 10, s);
        finish_done(s, 5);
        check("reload_ram0", ram[0],             32'h0000_5555);
        check("reload_last", 32'(last_wr_addr),  32'h0);
        check("reload_csum", checksum,           CSUM_ON ? 32'h0000_5555 : 32'h0);

        check("wen_without_hold", 32'(hold_viol), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
